// File: rtl/idct_transpose_buffer.sv
// idct_transpose_buffer: ping-pong 8x8 transpose buffer between the row and column IDCT passes.
// Define IDCT_TPOSE_ROUND_EN to round half up on descale instead of truncating.
module idct_transpose_buffer #(
  parameter int DATA_WIDTH    = 64,
  parameter int DESCALE_SHIFT = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_row [7:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_col [7:0],
  output logic                  out_last
);

`ifdef IDCT_TPOSE_ROUND_EN
  localparam logic [DATA_WIDTH-1:0] ROUND_BIAS =
    ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << DESCALE_SHIFT) >> 1;
`endif

  logic [DATA_WIDTH-1:0]        mem [2][8][8];
  logic [1:0]                   full;
  logic                         wbank;
  logic                         rbank;
  logic [2:0]                   wrow;
  logic [2:0]                   rcol;
  logic                         in_fire;
  logic                         out_fire;
  logic signed [DATA_WIDTH-1:0] biased  [8];
  logic signed [DATA_WIDTH-1:0] shifted [8];

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign out_last  = out_valid && (rcol == 3'd7);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Storage is deliberately left unreset; the full flags decide what is visible.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < 8; k++) begin
        mem[wbank][wrow][k] <= in_row[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wrow  <= 3'd0;
      rcol  <= 3'd0;
      full  <= 2'b00;
    end else begin
      if (in_fire) begin
        wrow <= wrow + 3'd1;
        if (wrow == 3'd7) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      // A write fill and a read drain always target different banks, so both bit updates stand.
      if (out_fire) begin
        rcol <= rcol + 3'd1;
        if (rcol == 3'd7) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
`ifdef IDCT_TPOSE_ROUND_EN
      biased[r] = mem[rbank][r][rcol] + ROUND_BIAS;
`else
      biased[r] = mem[rbank][r][rcol];
`endif
      shifted[r] = biased[r] >>> DESCALE_SHIFT;
      out_col[r] = out_valid ? shifted[r] : '0;
    end
  end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// tb_idct_transpose_buffer: directed tests checked every cycle against a queue-of-blocks model.
// Honours IDCT_TPOSE_ROUND_EN so the same bench covers both descale modes.
module tb_idct_transpose_buffer;
  localparam int DW    = 64;
  localparam int SHIFT = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_row [7:0];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_col [7:0];
  logic          out_last;

  int     checks  = 0;
  int     errors  = 0;
  bit     armed   = 1'b0;
  longint done_q [$];
  longint part_q [$];
  int     col_idx = 0;
  int     low_cnt;
  int     valid_cnt;
  longint exp_half;
  longint exp_neg_half;

  idct_transpose_buffer #(.DATA_WIDTH(DW), .DESCALE_SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic longint descale(longint x);
`ifdef IDCT_TPOSE_ROUND_EN
    return (x + ((longint'(1) << SHIFT) >>> 1)) >>> SHIFT;
`else
    return x >>> SHIFT;
`endif
  endfunction

  task automatic check_output(string name, logic [DW-1:0] actual, logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), $signed(expected));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(bit valid, longint first, longint stride);
    in_valid = valid;
    for (int k = 0; k < 8; k++) in_row[k] = first + longint'(k) * stride;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) step();
    check_output("drain_done", out_valid, 1'b0);
  endtask

  // Model: completed blocks are whole row-major 64-entry chunks; at most two may be held.
  always @(posedge clk) begin
    bit exp_ready;
    bit exp_valid;
    if (rst) begin
      done_q.delete();
      part_q.delete();
      col_idx = 0;
      armed   = 1'b1;
    end else if (armed) begin
      exp_ready = done_q.size() < 128;
      exp_valid = done_q.size() >= 64;
      if (exp_valid && out_ready) begin
        if (col_idx == 7) begin
          repeat (64) void'(done_q.pop_front());
          col_idx = 0;
        end else begin
          col_idx++;
        end
      end
      if (exp_ready && in_valid) begin
        for (int k = 0; k < 8; k++) part_q.push_back(longint'(in_row[k]));
        if (part_q.size() == 64) begin
          foreach (part_q[i]) done_q.push_back(part_q[i]);
          part_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      bit exp_valid;
      exp_valid = done_q.size() >= 64;
      check_output("in_ready", in_ready, done_q.size() < 128);
      check_output("out_valid", out_valid, exp_valid);
      check_output("out_last", out_last, exp_valid && (col_idx == 7));
      for (int r = 0; r < 8; r++) begin
        if (exp_valid) check_output("out_col", out_col[r], descale(done_q[r*8 + col_idx]));
        else check_output("out_col_idle", out_col[r], '0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef IDCT_TPOSE_ROUND_EN
    exp_half     = 1;
    exp_neg_half = 0;
`else
    exp_half     = 0;
    exp_neg_half = -1;
`endif
    rst       = 1'b1;
    out_ready = 1'b0;
    apply_stimulus(1'b0, 0, 0);
    step();
    step();
    rst = 1'b0;
    check_output("reset_in_ready", in_ready, 1'b1);
    check_output("reset_out_valid", out_valid, 1'b0);
    check_output("reset_out_last", out_last, 1'b0);

    $display("[TB] single block");
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) check_output("blk_early_valid", out_valid, 1'b0);
      apply_stimulus(1'b1, longint'(8*r) << SHIFT, longint'(1) << SHIFT);
      step();
    end
    in_valid = 1'b0;
    check_output("blk_latency_valid", out_valid, 1'b1);
    check_output("blk_not_last", out_last, 1'b0);
    for (int r = 0; r < 8; r++) check_output("blk_col0", out_col[r], 8*r);
    repeat (7) step();
    check_output("blk_last", out_last, 1'b1);
    check_output("blk_col7_r2", out_col[2], 23);
    step();
    check_output("blk_done", out_valid, 1'b0);

    $display("[TB] streaming four blocks");
    low_cnt   = 0;
    valid_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 32 && !in_ready) low_cnt++;
      if (cyc >= 8 && out_valid) valid_cnt++;
      if (cyc < 32) apply_stimulus(1'b1, (longint'(cyc*8) - 100) << SHIFT, longint'(1) << SHIFT);
      else in_valid = 1'b0;
      step();
    end
    check_output("stream_ready_drops", low_cnt, 0);
    check_output("stream_valid_cycles", valid_cnt, 32);
    check_output("stream_end", out_valid, 1'b0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      apply_stimulus(1'b1, longint'(1000 + 8*r) << SHIFT, -(longint'(1) << SHIFT));
      step();
    end
    check_output("bp_full", in_ready, 1'b0);
    apply_stimulus(1'b1, longint'(5555) << SHIFT, longint'(1) << SHIFT);
    step();
    apply_stimulus(1'b0, 9999, 3);
    step();
    apply_stimulus(1'b1, -(longint'(7777) << SHIFT), 1);
    step();
    check_output("bp_still_full", in_ready, 1'b0);
    apply_stimulus(1'b1, longint'(2000) << SHIFT, longint'(1) << SHIFT);
    out_ready = 1'b1;
    check_output("bp_first_col", out_col[1], 1008);
    repeat (7) step();
    check_output("bp_hold_until_last", in_ready, 1'b0);
    step();
    check_output("bp_recover", in_ready, 1'b1);
    check_output("bp_next_block", out_valid, 1'b1);
    step();
    for (int r = 1; r < 8; r++) begin
      apply_stimulus(1'b1, longint'(2000 + 8*r) << SHIFT, longint'(1) << SHIFT);
      step();
    end
    drain();

    $display("[TB] sign and rounding");
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(1'b1, longint'(r) << SHIFT, 0);
      if (r == 0) begin
        in_row[0] = 64'h2000;
        in_row[1] = -64'sh2000;
        in_row[2] = -(longint'(5) << SHIFT);
      end
      step();
    end
    in_valid = 1'b0;
    check_output("rnd_half", out_col[0], exp_half);
    out_ready = 1'b1;
    step();
    check_output("rnd_neg_half", out_col[0], exp_neg_half);
    step();
    check_output("rnd_neg_five", out_col[0], -64'sd5);
    check_output("rnd_row3", out_col[3], 3);
    drain();

    $display("[TB] reset mid-operation");
    for (int r = 0; r < 5; r++) begin
      apply_stimulus(1'b1, longint'(300 + r) << SHIFT, longint'(1) << SHIFT);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("rst_in_ready", in_ready, 1'b1);
    check_output("rst_out_valid", out_valid, 1'b0);
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(1'b1, longint'(7) << SHIFT, 0);
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) check_output("rst_new_block", out_col[r], 7);
      check_output("rst_last", out_last, c == 7);
      step();
    end
    check_output("rst_done", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
